// File: rtl/background_tile_fetcher.sv
// rtl/background_tile_fetcher.sv - per-tile NT/AT/pattern fetch cadence with staged tile output
// Optional dummy nametable reads at dots 337/339: define BG_FETCH_DUMMY_NT_EN.
module background_tile_fetcher #(
    parameter int FETCH_END_DOT  = 256,
    parameter int PRERENDER_LINE = 261
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_EN,
    input  logic        rendering_EN,
    input  logic [8:0]  cycle,
    input  logic [8:0]  scanline,
    input  logic [14:0] vramAddr,
    input  logic        patternTableSel,
    input  logic [7:0]  vramData,
    output logic [13:0] ppuAddr,
    output logic        readStrobe,
    output logic [1:0]  tileAttr,
    output logic [7:0]  tileLowByte,
    output logic [7:0]  tileHighByte,
    output logic        loadOut,
    output logic        incHoriz,
    output logic        incVert
);

    localparam logic [8:0] END_DOT  = FETCH_END_DOT[8:0];
    localparam logic [8:0] PRE_LINE = PRERENDER_LINE[8:0];

    logic [7:0]  nt_byte;
    logic [1:0]  at_bits;
    logic [7:0]  pt_low;
    logic [7:0]  pt_high;
    logic        tile_valid;
    logic        load_pending;
    logic [13:0] addr_hold;

    logic        fetch_line;
    logic        fetch_dot;
    logic        fetch_active;
    logic        dummy_nt;
    logic        issue;
    logic [2:0]  phase;
    logic [2:0]  at_shift;
    logic [13:0] addr_next;
    logic [13:0] nt_addr;

    assign fetch_line   = rendering_EN && ((scanline <= 9'd239) || (scanline == PRE_LINE));
    assign fetch_dot    = ((cycle >= 9'd1) && (cycle <= END_DOT)) ||
                          ((cycle >= 9'd321) && (cycle <= 9'd336));
    assign fetch_active = fetch_line && fetch_dot && !reset;
    // Low three bits of (cycle - 1) equal cycle[2:0] - 1 modulo 8.
    assign phase        = cycle[2:0] - 3'd1;
    assign at_shift     = {vramAddr[6], vramAddr[1], 1'b0};
    assign nt_addr      = {2'b10, vramAddr[11:0]};

`ifdef BG_FETCH_DUMMY_NT_EN
    assign dummy_nt = fetch_line && !reset && ((cycle == 9'd337) || (cycle == 9'd339));
`else
    assign dummy_nt = 1'b0;
`endif

    always_comb begin
        issue     = 1'b0;
        addr_next = addr_hold;
        if (fetch_active) begin
            case (phase)
                3'd0: begin
                    issue     = 1'b1;
                    addr_next = nt_addr;
                end
                3'd2: begin
                    issue     = 1'b1;
                    addr_next = {2'b10, vramAddr[11:10], 4'b1111, vramAddr[9:7], vramAddr[4:2]};
                end
                3'd4: begin
                    issue     = 1'b1;
                    addr_next = {1'b0, patternTableSel, nt_byte, 1'b0, vramAddr[14:12]};
                end
                3'd6: begin
                    issue     = 1'b1;
                    addr_next = {1'b0, patternTableSel, nt_byte, 1'b1, vramAddr[14:12]};
                end
                default: ;
            endcase
        end else if (dummy_nt) begin
            issue     = 1'b1;
            addr_next = nt_addr;
        end
    end

    assign readStrobe = issue;
    assign ppuAddr    = reset ? 14'h0000 : (issue ? addr_next : addr_hold);
    assign loadOut    = clock_EN && load_pending && !reset;
    assign incHoriz   = clock_EN && fetch_active && (phase == 3'd7);
    assign incVert    = clock_EN && fetch_active && (cycle == END_DOT);

    always_ff @(posedge clock) begin
        if (reset) begin
            nt_byte      <= 8'h00;
            at_bits      <= 2'b00;
            pt_low       <= 8'h00;
            pt_high      <= 8'h00;
            tile_valid   <= 1'b0;
            load_pending <= 1'b0;
            addr_hold    <= 14'h0000;
            tileAttr     <= 2'b00;
            tileLowByte  <= 8'h00;
            tileHighByte <= 8'h00;
        end else if (clock_EN) begin
            load_pending <= 1'b0;
            if (issue) begin
                addr_hold <= addr_next;
            end
            if (fetch_active) begin
                case (phase)
                    3'd0: tile_valid <= 1'b1;
                    3'd1: nt_byte    <= vramData;
                    3'd3: at_bits    <= vramData[at_shift +: 2];
                    3'd5: pt_low     <= vramData;
                    3'd7: begin
                        pt_high    <= vramData;
                        tile_valid <= 1'b0;
                        // The high plane arrives on this same edge, so it bypasses staging.
                        if (tile_valid) begin
                            tileAttr     <= at_bits;
                            tileLowByte  <= pt_low;
                            tileHighByte <= vramData;
                            load_pending <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                tile_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_background_tile_fetcher.sv
// tb/tb_background_tile_fetcher.sv - directed self-checking bench for background_tile_fetcher
module tb_background_tile_fetcher;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_EN;
    logic        rendering_EN;
    logic [8:0]  cycle;
    logic [8:0]  scanline;
    logic [14:0] vramAddr;
    logic        patternTableSel;
    logic [7:0]  vramData;
    logic [13:0] ppuAddr;
    logic        readStrobe;
    logic [1:0]  tileAttr;
    logic [7:0]  tileLowByte;
    logic [7:0]  tileHighByte;
    logic        loadOut;
    logic        incHoriz;
    logic        incVert;

    int checks   = 0;
    int failures = 0;
    logic [7:0] nt_d, at_d, lo_d, hi_d;

    background_tile_fetcher #(.FETCH_END_DOT(256), .PRERENDER_LINE(261)) dut (
        .clock(clock), .reset(reset), .clock_EN(clock_EN), .rendering_EN(rendering_EN),
        .cycle(cycle), .scanline(scanline), .vramAddr(vramAddr),
        .patternTableSel(patternTableSel), .vramData(vramData),
        .ppuAddr(ppuAddr), .readStrobe(readStrobe), .tileAttr(tileAttr),
        .tileLowByte(tileLowByte), .tileHighByte(tileHighByte),
        .loadOut(loadOut), .incHoriz(incHoriz), .incVert(incVert)
    );

    always #5 clock = ~clock;

    // Data for a read is presented during the dot after its address phase.
    task automatic dot_begin(input int c, input int sl);
        cycle    = 9'(c);
        scanline = 9'(sl);
        case ((c - 1) & 7)
            1:       vramData = nt_d;
            3:       vramData = at_d;
            5:       vramData = lo_d;
            7:       vramData = hi_d;
            default: vramData = 8'h00;
        endcase
        @(negedge clock);
    endtask

    task automatic dot_end;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; clock_EN = 1'b1; rendering_EN = 1'b1;
        cycle = 9'd8; scanline = 9'd0; vramAddr = 15'h0000; patternTableSel = 1'b1; vramData = 8'hFF;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        if (ppuAddr !== 14'h0) begin failures++; $display("FAIL reset_ppuAddr got=%h exp=0", ppuAddr); end checks++;
        if (readStrobe !== 1'b0) begin failures++; $display("FAIL reset_readStrobe got=%b exp=0", readStrobe); end checks++;
        if (tileAttr !== 2'b0) begin failures++; $display("FAIL reset_tileAttr got=%h exp=0", tileAttr); end checks++;
        if (tileLowByte !== 8'h0) begin failures++; $display("FAIL reset_tileLow got=%h exp=0", tileLowByte); end checks++;
        if (tileHighByte !== 8'h0) begin failures++; $display("FAIL reset_tileHigh got=%h exp=0", tileHighByte); end checks++;
        if (loadOut !== 1'b0) begin failures++; $display("FAIL reset_loadOut got=%b exp=0", loadOut); end checks++;
        if (incHoriz !== 1'b0) begin failures++; $display("FAIL reset_incHoriz got=%b exp=0", incHoriz); end checks++;
        if (incVert !== 1'b0) begin failures++; $display("FAIL reset_incVert got=%b exp=0", incVert); end checks++;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch;
        vramAddr = 15'h0000; patternTableSel = 1'b1;
        nt_d = 8'h24; at_d = 8'hE4; lo_d = 8'hAA; hi_d = 8'h55;
        for (int c = 0; c <= 10; c++) begin
            dot_begin(c, 0);
            case (c)
                1: begin
                    if (ppuAddr !== 14'h2000) begin failures++; $display("FAIL basic_addr_d1 got=%h exp=2000", ppuAddr); end checks++;
                    if (readStrobe !== 1'b1) begin failures++; $display("FAIL basic_rs_d1 got=%b exp=1", readStrobe); end checks++;
                end
                2: begin
                    if (readStrobe !== 1'b0) begin failures++; $display("FAIL basic_rs_d2 got=%b exp=0", readStrobe); end checks++;
                    if (ppuAddr !== 14'h2000) begin failures++; $display("FAIL basic_hold_d2 got=%h exp=2000", ppuAddr); end checks++;
                end
                3: if (ppuAddr !== 14'h23C0) begin failures++; $display("FAIL basic_addr_d3 got=%h exp=23c0", ppuAddr); end
                5: if (ppuAddr !== 14'h1240) begin failures++; $display("FAIL basic_addr_d5 got=%h exp=1240", ppuAddr); end
                7: if (ppuAddr !== 14'h1248) begin failures++; $display("FAIL basic_addr_d7 got=%h exp=1248", ppuAddr); end
                8: begin
                    if (incHoriz !== 1'b1) begin failures++; $display("FAIL basic_incH_d8 got=%b exp=1", incHoriz); end checks++;
                    if (loadOut !== 1'b0) begin failures++; $display("FAIL basic_load_d8 got=%b exp=0", loadOut); end checks++;
                    if (incVert !== 1'b0) begin failures++; $display("FAIL basic_incV_d8 got=%b exp=0", incVert); end
                end
                9: begin
                    if (loadOut !== 1'b1) begin failures++; $display("FAIL basic_load_d9 got=%b exp=1", loadOut); end checks++;
                    if (tileAttr !== 2'd0) begin failures++; $display("FAIL basic_attr got=%h exp=0", tileAttr); end checks++;
                    if (tileLowByte !== 8'hAA) begin failures++; $display("FAIL basic_low got=%h exp=aa", tileLowByte); end checks++;
                    if (tileHighByte !== 8'h55) begin failures++; $display("FAIL basic_high got=%h exp=55", tileHighByte); end checks++;
                    if (incHoriz !== 1'b0) begin failures++; $display("FAIL basic_incH_d9 got=%b exp=0", incHoriz); end
                end
                10: if (loadOut !== 1'b0) begin failures++; $display("FAIL basic_load_d10 got=%b exp=0", loadOut); end
                default: ;
            endcase
            if (c == 3 || c == 5 || c == 7 || c == 8 || c == 9 || c == 10) checks++;
            dot_end();
        end
    endtask

    task automatic test_attr_quadrant;
        logic [14:0] v_tab [2];
        logic [1:0]  a_tab [2];
        v_tab[0] = 15'h0042; a_tab[0] = 2'd3;
        v_tab[1] = 15'h0002; a_tab[1] = 2'd1;
        at_d = 8'hE4;
        for (int k = 0; k < 2; k++) begin
            vramAddr = v_tab[k];
            for (int c = 0; c <= 9; c++) begin
                dot_begin(c, 0);
                if (c == 3) begin
                    if (ppuAddr !== 14'h23C0) begin failures++; $display("FAIL attr_addr v=%h got=%h exp=23c0", vramAddr, ppuAddr); end checks++;
                end
                if (c == 9) begin
                    if (loadOut !== 1'b1) begin failures++; $display("FAIL attr_load v=%h got=%b exp=1", vramAddr, loadOut); end checks++;
                    if (tileAttr !== a_tab[k]) begin failures++; $display("FAIL attr_bits v=%h got=%0d exp=%0d", vramAddr, tileAttr, a_tab[k]); end checks++;
                end
                dot_end();
            end
        end
    endtask

    task automatic test_line_end;
        logic fd, eh, ev, el, er;
        vramAddr = 15'h0000;
        for (int c = 0; c <= 340; c++) begin
            fd = ((c >= 1) && (c <= 256)) || ((c >= 321) && (c <= 336));
            eh = fd && (((c - 1) % 8) == 7);
            ev = (c == 256);
            el = ((c >= 9) && (c <= 257) && (((c - 1) % 8) == 0)) || (c == 329) || (c == 337);
`ifdef BG_FETCH_DUMMY_NT_EN
            er = (fd && (((c - 1) % 2) == 0)) || (c == 337) || (c == 339);
`else
            er = fd && (((c - 1) % 2) == 0);
`endif
            dot_begin(c, 100);
            if (incHoriz !== eh) begin failures++; $display("FAIL line_incH dot=%0d got=%b exp=%b", c, incHoriz, eh); end checks++;
            if (incVert !== ev) begin failures++; $display("FAIL line_incV dot=%0d got=%b exp=%b", c, incVert, ev); end checks++;
            if (loadOut !== el) begin failures++; $display("FAIL line_load dot=%0d got=%b exp=%b", c, loadOut, el); end checks++;
            if (readStrobe !== er) begin failures++; $display("FAIL line_rs dot=%0d got=%b exp=%b", c, readStrobe, er); end checks++;
            dot_end();
        end
    endtask

    task automatic test_clock_gating;
        logic [13:0] ea;
        vramAddr = 15'h0000; patternTableSel = 1'b0;
        nt_d = 8'h3C; at_d = 8'h1B; lo_d = 8'h0F; hi_d = 8'hF0;
        for (int c = 0; c <= 10; c++) begin
            case (c)
                1: ea = 14'h2000;
                3: ea = 14'h23C0;
                5: ea = 14'h03C0;
                7: ea = 14'h03C8;
                default: ea = 14'h0000;
            endcase
            clock_EN = 1'b1;
            dot_begin(c, 0);
            if (ea != 14'h0000) begin
                if (ppuAddr !== ea) begin failures++; $display("FAIL gate_addr_en dot=%0d got=%h exp=%h", c, ppuAddr, ea); end checks++;
            end
            if (incHoriz !== (c == 8)) begin failures++; $display("FAIL gate_incH_en dot=%0d got=%b", c, incHoriz); end checks++;
            if (loadOut !== (c == 9)) begin failures++; $display("FAIL gate_load_en dot=%0d got=%b", c, loadOut); end checks++;
            if (c == 9) begin
                if (tileAttr !== 2'd3) begin failures++; $display("FAIL gate_attr got=%h exp=3", tileAttr); end checks++;
                if (tileLowByte !== 8'h0F) begin failures++; $display("FAIL gate_low got=%h exp=0f", tileLowByte); end checks++;
                if (tileHighByte !== 8'hF0) begin failures++; $display("FAIL gate_high got=%h exp=f0", tileHighByte); end checks++;
            end
            dot_end();
            // Garbage on the bus while disabled must never be captured.
            clock_EN = 1'b0;
            vramData = 8'hFF;
            @(negedge clock);
            if (ea != 14'h0000) begin
                if (ppuAddr !== ea) begin failures++; $display("FAIL gate_addr_dis dot=%0d got=%h exp=%h", c, ppuAddr, ea); end checks++;
            end
            if (incHoriz !== 1'b0) begin failures++; $display("FAIL gate_incH_dis dot=%0d got=%b exp=0", c, incHoriz); end checks++;
            if (loadOut !== 1'b0) begin failures++; $display("FAIL gate_load_dis dot=%0d got=%b exp=0", c, loadOut); end checks++;
            dot_end();
        end
        clock_EN = 1'b1;
    endtask

    task automatic test_abort;
        vramAddr = 15'h0000; patternTableSel = 1'b0;
        nt_d = 8'h3C; at_d = 8'h1B; lo_d = 8'h77; hi_d = 8'h88;
        for (int c = 0; c <= 17; c++) begin
            rendering_EN = !((c == 4) || (c == 5));
            dot_begin(c, 0);
            if (c == 5) begin
                if (readStrobe !== 1'b0) begin failures++; $display("FAIL abort_rs_d5 got=%b exp=0", readStrobe); end checks++;
            end
            if (c == 9) begin
                if (loadOut !== 1'b0) begin failures++; $display("FAIL abort_load_d9 got=%b exp=0", loadOut); end checks++;
                if (tileLowByte !== 8'h0F) begin failures++; $display("FAIL abort_hold_low got=%h exp=0f", tileLowByte); end checks++;
            end
            if (c == 17) begin
                if (loadOut !== 1'b1) begin failures++; $display("FAIL abort_load_d17 got=%b exp=1", loadOut); end checks++;
                if (tileLowByte !== 8'h77) begin failures++; $display("FAIL abort_low got=%h exp=77", tileLowByte); end checks++;
                if (tileHighByte !== 8'h88) begin failures++; $display("FAIL abort_high got=%h exp=88", tileHighByte); end checks++;
            end
            dot_end();
        end
        rendering_EN = 1'b1;
    endtask

    task automatic test_reset_mid_tile;
        nt_d = 8'h11; at_d = 8'h00; lo_d = 8'h5A; hi_d = 8'hA5;
        for (int c = 0; c <= 17; c++) begin
            reset = (c == 5);
            dot_begin(c, 0);
            if (c == 5) begin
                if (ppuAddr !== 14'h0) begin failures++; $display("FAIL rstmid_addr_d5 got=%h exp=0", ppuAddr); end checks++;
                if (readStrobe !== 1'b0) begin failures++; $display("FAIL rstmid_rs_d5 got=%b exp=0", readStrobe); end checks++;
            end
            if (c == 6) begin
                if (tileLowByte !== 8'h0) begin failures++; $display("FAIL rstmid_low_d6 got=%h exp=0", tileLowByte); end checks++;
                if (tileHighByte !== 8'h0) begin failures++; $display("FAIL rstmid_high_d6 got=%h exp=0", tileHighByte); end checks++;
                if (ppuAddr !== 14'h0) begin failures++; $display("FAIL rstmid_hold_d6 got=%h exp=0", ppuAddr); end checks++;
            end
            if (c == 9) begin
                if (loadOut !== 1'b0) begin failures++; $display("FAIL rstmid_load_d9 got=%b exp=0", loadOut); end checks++;
            end
            if (c == 17) begin
                if (loadOut !== 1'b1) begin failures++; $display("FAIL rstmid_load_d17 got=%b exp=1", loadOut); end checks++;
                if (tileLowByte !== 8'h5A) begin failures++; $display("FAIL rstmid_low got=%h exp=5a", tileLowByte); end checks++;
                if (tileHighByte !== 8'hA5) begin failures++; $display("FAIL rstmid_high got=%h exp=a5", tileHighByte); end checks++;
            end
            dot_end();
        end
        reset = 1'b0;
    endtask

    task automatic test_dummy_nt;
        logic er;
        vramAddr = 15'h0123; patternTableSel = 1'b0;
        nt_d = 8'h3C; at_d = 8'h00; lo_d = 8'h12; hi_d = 8'h34;
        for (int c = 320; c <= 340; c++) begin
            dot_begin(c, 261);
            if (c == 329 || c == 337) begin
                if (loadOut !== 1'b1) begin failures++; $display("FAIL dummy_load dot=%0d got=%b exp=1", c, loadOut); end checks++;
            end
            if (c >= 337) begin
`ifdef BG_FETCH_DUMMY_NT_EN
                er = (c == 337) || (c == 339);
`else
                er = 1'b0;
`endif
                if (readStrobe !== er) begin failures++; $display("FAIL dummy_rs dot=%0d got=%b exp=%b", c, readStrobe, er); end checks++;
                if (incHoriz !== 1'b0) begin failures++; $display("FAIL dummy_incH dot=%0d got=%b exp=0", c, incHoriz); end checks++;
            end
            if (c == 337) begin
`ifdef BG_FETCH_DUMMY_NT_EN
                if (ppuAddr !== 14'h2123) begin failures++; $display("FAIL dummy_addr got=%h exp=2123", ppuAddr); end checks++;
`else
                if (ppuAddr !== 14'h03C8) begin failures++; $display("FAIL dummy_hold got=%h exp=03c8", ppuAddr); end checks++;
`endif
            end
            dot_end();
        end
    endtask

    initial begin
        nt_d = 8'h00; at_d = 8'h00; lo_d = 8'h00; hi_d = 8'h00;
        test_reset();
        test_basic_fetch();
        test_attr_quadrant();
        test_line_end();
        test_clock_gating();
        test_abort();
        test_reset_mid_tile();
        test_dummy_nt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
